// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, valid/ready handshake.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle combinational one.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_func3,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_src_1,
  input  logic [XLEN-1:0] i_src_2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int PW    = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  function automatic logic [XLEN-1:0] f_sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] f_fit(input logic [XLEN-1:0] v, input logic word);
    return word ? f_sext32(v[31:0]) : v;
  endfunction

  // Magnitude at operand width; the most-negative value maps onto itself as an unsigned number.
  function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] v, input logic neg,
                                            input logic word);
    logic [XLEN-1:0] m;
    m = '0;
    if (word) m[31:0] = neg ? -v[31:0] : v[31:0];
    else      m = neg ? -v : v;
    return m;
  endfunction

  function automatic logic [XLEN-1:0] f_mul_sel(input logic [PW-1:0] p, input logic neg,
                                                input logic hi, input logic word);
    logic [PW-1:0] s;
    s = neg ? -p : p;
    if (word) return f_sext32(s[31:0]);
    return hi ? s[PW-1:XLEN] : s[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] f_div_sel(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                                input logic neg, input logic rem, input logic word);
    logic [XLEN-1:0] v;
    v = rem ? r : q;
    v = neg ? -v : v;
    return word ? f_sext32(v[31:0]) : v;
  endfunction

  state_t            r_state;
  logic              r_valid;
  logic              r_busy;
  logic [XLEN-1:0]   r_result;
  logic [2:0]        r_op;
  logic              r_word;
  logic              r_neg;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [PW-1:0]     r_acc;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;

  logic              w_is_div, w_div_s, w_s1_en, w_s2_en;
  logic              w_neg1, w_neg2, w_res_neg;
  logic [2:0]        w_op;
  logic [XLEN-1:0]   w_a, w_b;
  logic              w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0]   w_spec_res;

  // Accept-side decode: signedness, magnitudes, result sign and the divide corner cases
  always_comb begin
    w_is_div = i_func3[2];
    w_div_s  = ~i_func3[0];
    w_op     = (i_word && !i_func3[2]) ? 3'b000 : i_func3;
    w_s1_en  = w_is_div ? w_div_s : (w_op[1:0] != 2'b11);
    w_s2_en  = w_is_div ? w_div_s : (w_op[1] == 1'b0);
    w_neg1   = w_s1_en & (i_word ? i_src_1[31] : i_src_1[XLEN-1]);
    w_neg2   = w_s2_en & (i_word ? i_src_2[31] : i_src_2[XLEN-1]);
    w_a      = f_mag(i_src_1, w_neg1, i_word);
    w_b      = f_mag(i_src_2, w_neg2, i_word);
    w_res_neg = (w_is_div && i_func3[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
    w_b_zero = i_word ? (i_src_2[31:0] == '0) : (i_src_2 == '0);
    w_ovf    = w_div_s && (i_word
               ? (i_src_1[31:0] == 32'h8000_0000 && i_src_2[31:0] == '1)
               : (i_src_1 == {1'b1, {(XLEN-1){1'b0}}} && i_src_2 == '1));
    w_special = w_is_div && (w_b_zero || w_ovf);
    if (w_b_zero) w_spec_res = i_func3[1] ? f_fit(i_src_1, i_word) : '1;
    else          w_spec_res = i_func3[1] ? '0 : f_fit(i_src_1, i_word);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [PW-1:0]   w_fast_prod;
  logic [XLEN-1:0] w_fast_res;
  always_comb begin
    w_fast_prod = PW'(w_a) * PW'(w_b);
    w_fast_res  = f_mul_sel(w_fast_prod, w_res_neg, w_op[1:0] != 2'b00, i_word);
  end
`endif

  logic [PW-1:0]   w_acc_nxt;
  logic [XLEN:0]   w_rsh, w_rdiff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_calc_res;

  // One multiplier bit (MSB first) or one quotient bit per CALC cycle
  always_comb begin
    w_acc_nxt = {r_acc[PW-2:0], 1'b0} + (r_b[r_cnt] ? PW'(r_a) : '0);
    w_rsh     = {r_rem, r_a[r_cnt]};
    w_rdiff   = w_rsh - {1'b0, r_b};
    w_ge      = (w_rsh >= {1'b0, r_b});
    w_rem_nxt = w_ge ? w_rdiff[XLEN-1:0] : w_rsh[XLEN-1:0];
    w_quo_nxt = r_quo;
    w_quo_nxt[r_cnt] = w_ge;
    w_calc_res = r_op[2] ? f_div_sel(w_quo_nxt, w_rem_nxt, r_neg, r_op[1], r_word)
                         : f_mul_sel(w_acc_nxt, r_neg, r_op[1:0] != 2'b00, r_word);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_op   <= w_op;
            r_word <= i_word;
            r_neg  <= w_res_neg;
            r_a    <= w_a;
            r_b    <= w_b;
            r_acc  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= i_word ? CNT_W'(31) : CNT_W'(XLEN-1);
            r_busy <= 1'b1;
            if (w_special) begin
              r_result <= w_spec_res;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!w_is_div) begin
              r_result <= w_fast_res;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
`endif
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_result <= w_calc_res;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready  = (r_state == S_IDLE) && !i_flush;
  assign o_valid  = r_valid;
  assign o_busy   = r_busy;
  assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=64): results, latencies, corner cases, flush, backpressure, reset.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MULW_LAT = 1;
`else
  localparam int MUL_LAT  = 65;
  localparam int MULW_LAT = 33;
`endif
  localparam int DIV_LAT  = 65;
  localparam int DIVW_LAT = 33;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_func3 = 3'b000;
  logic        i_word = 1'b0;
  logic [63:0] i_src_1 = '0;
  logic [63:0] i_src_2 = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [63:0] o_result;
  logic        o_busy;

  int n_checks = 0;
  int n_fails  = 0;

  muldiv_unit #(.XLEN(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_func3(i_func3), .i_word(i_word), .i_src_1(i_src_1), .i_src_2(i_src_2),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one op, measure cycles from accept to o_valid, check result; consume it if i_ready is high.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    check({tag, " ready"}, 64'(o_ready), 64'd1);
    i_func3 = f3; i_word = w; i_src_1 = a; i_src_2 = b; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, o_result, exp);
    if (i_ready) tick();
  endtask

  initial begin
    // Reset
    i_rst = 1'b1;
    tick();
    tick();
    check("rst valid", 64'(o_valid), 64'd0);
    check("rst result", o_result, 64'd0);
    check("rst ready", 64'(o_ready), 64'd1);
    check("rst busy", 64'(o_busy), 64'd0);
    i_rst = 1'b0;
    tick();

    // Multiply family
    run_op("MUL 7*-3", 3'b000, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
    run_op("MULH", 3'b001, 1'b0, '1, '1, 64'h0, MUL_LAT);
    run_op("MULHU", 3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT);
    run_op("MULHSU", 3'b010, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT);
    run_op("MULH big", 3'b001, 1'b0, 64'h4000_0000_0000_0000, 64'd8, 64'd2, MUL_LAT);
    run_op("MULW", 3'b000, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MULW_LAT);
    run_op("MULHW rsv", 3'b011, 1'b1, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFB,
           64'hFFFF_FFFF_FFFF_FFF1, MULW_LAT);

    // Divide family
    run_op("DIV -7/2", 3'b100, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT);
    run_op("REM -7/2", 3'b110, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, DIV_LAT);
    run_op("DIVU", 3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, DIV_LAT);
    run_op("REMU", 3'b111, 1'b0, 64'd1000, 64'd7, 64'd6, DIV_LAT);
    run_op("DIVUW", 3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, DIVW_LAT);
    run_op("REMW", 3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, DIVW_LAT);

    // Corner cases resolved one cycle after accept
    run_op("DIV x/0", 3'b100, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("REMU 5/0", 3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    run_op("DIV ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run_op("REM ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1);
    run_op("DIVW ovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("REMUW x/0", 3'b111, 1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000,
           64'hFFFF_FFFF_8000_0001, 1);

    // Flush 10 cycles into a divide
    i_func3 = 3'b100; i_word = 1'b0; i_src_1 = 64'd100; i_src_2 = 64'd3; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    check("flush busy before", 64'(o_busy), 64'd1);
    check("flush ready before", 64'(o_ready), 64'd0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    #1;
    check("flush ready after", 64'(o_ready), 64'd1);
    check("flush busy after", 64'(o_busy), 64'd0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 80; k++) begin
        if (o_valid) seen++;
        tick();
      end
      check("flush no valid", 64'(seen), 64'd0);
    end

    // Backpressure in DONE
    i_ready = 1'b0;
    run_op("DIVU bp", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, DIV_LAT);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp valid held", 64'(o_valid), 64'd1);
      check("bp result held", o_result, 64'd14);
    end
    i_ready = 1'b1;
    tick();
    check("bp released valid", 64'(o_valid), 64'd0);
    check("bp released ready", 64'(o_ready), 64'd1);

    // Reset in the middle of CALC
    i_func3 = 3'b000; i_word = 1'b0; i_src_1 = 64'd9; i_src_2 = 64'd9; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
`ifndef MULDIV_FAST_MUL_EN
    check("midrst busy before", 64'(o_busy), 64'd1);
`endif
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("midrst busy", 64'(o_busy), 64'd0);
    check("midrst valid", 64'(o_valid), 64'd0);
    check("midrst result", o_result, 64'd0);
    check("midrst ready", 64'(o_ready), 64'd1);

    // Unit still works after reset
    run_op("DIV after rst", 3'b100, 1'b0, 64'd50, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF6, DIV_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
